// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-memory port of mem_ctrl between the CPU
// core (m0) and a secondary master (m1). Single-beat req/gnt handshake; the
// command is forwarded in the grant cycle and read data returns one cycle later.
// Optional feature macro: MEM_ARB_FAIR_EN
//   defined   -> round-robin with a MAX_BURST consecutive-grant limit
//   undefined -> fixed priority, m0 always wins when it requests
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("mem_arbiter: MAX_BURST must be in 1..15");
    end

    cmd_t       cmd0, cmd1;
    logic       pick1;      // 1: m1 is the candidate winner this cycle
    logic [1:0] rvld_q;     // [0] -> m0, [1] -> m1 read response next cycle
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    assign cmd0 = {m0_we, m0_addr, m0_wdata};
    assign cmd1 = {m1_we, m1_addr, m1_wdata};

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic       last_q;     // most recent winner (1 = m1)
    logic [3:0] burst_q;    // consecutive grants to last_q, 0 after an idle cycle

    // Round-robin choice; the current owner keeps the port until its burst limit
    always_comb begin
        pick1 = m1_req;
        if (m0_req && m1_req) begin
            if (burst_q != 4'd0 && burst_q < BURST_LIM)
                pick1 = last_q;
            else
                pick1 = ~last_q;
        end
    end

    // Track last winner and saturating run length of consecutive grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;    // m0 wins the first tie after reset
            burst_q <= 4'd0;
        end else if (m0_gnt || m1_gnt) begin
            if (burst_q != 4'd0 && m1_gnt == last_q) begin
                if (burst_q != 4'hF)
                    burst_q <= burst_q + 4'd1;
            end else begin
                burst_q <= 4'd1;
            end
            last_q <= m1_gnt;
        end else begin
            burst_q <= 4'd0;
        end
    end
`else
    // Fixed priority: m1 only gets the port when m0 is not asking
    always_comb begin
        pick1 = m1_req & ~m0_req;
    end
`endif

    // Grants are forced low while reset is asserted, independent of the clock
    assign m0_gnt = rst_n & m0_req & ~pick1;
    assign m1_gnt = rst_n & m1_req &  pick1;

    // Forward the winning command; drive an all-zero idle command otherwise
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (m0_gnt) begin
            mem_addr  = cmd0.addr;
            mem_wdata = cmd0.wdata;
            mem_we    = cmd0.we;
            mem_re    = ~cmd0.we;
        end else if (m1_gnt) begin
            mem_addr  = cmd1.addr;
            mem_wdata = cmd1.wdata;
            mem_we    = cmd1.we;
            mem_re    = ~cmd1.we;
        end
    end

    // One-stage response pipeline: remember which master a read belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rvld_q <= 2'b00;
        else
            rvld_q <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end

    // Hold the last delivered read data per master
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvld_q[0]) rdata0_q <= mem_rdata;
            if (rvld_q[1]) rdata1_q <= mem_rdata;
        end
    end

    // mem_rdata is valid in the response cycle itself, so pass it straight through
    assign m0_rvalid = rvld_q[0];
    assign m1_rvalid = rvld_q[1];
    assign m0_rdata  = rvld_q[0] ? mem_rdata : rdata0_q;
    assign m1_rdata  = rvld_q[1] ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, a transaction-level model checked
// every cycle on the falling edge, plus hand-computed literal expectations.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_re;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stand-in driven by the DUT's memory port
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    // Transaction-level model state
    logic [DW-1:0] shadow [0:255];
    int            m_last;          // last winner index
    int            m_run;           // length of the current winner's run, 0 after idle
    logic          m_pv0, m_pv1;    // read response owed next cycle
    logic [DW-1:0] m_pd0, m_pd1, m_rd0, m_rd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Who should win right now: -1 none, 0 m0, 1 m1
    function automatic int exp_winner();
        if (!rst_n) return -1;
        if (m0_req && !m1_req) return 0;
        if (m1_req && !m0_req) return 1;
        if (!m0_req && !m1_req) return -1;
`ifdef MEM_ARB_FAIR_EN
        if (m_run > 0 && m_run < MB) return m_last;
        return 1 - m_last;
`else
        return 0;
`endif
    endfunction

    // Model update on each completed handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= 1; m_run <= 0;
            m_pv0 <= 1'b0; m_pv1 <= 1'b0;
            m_rd0 <= '0; m_rd1 <= '0;
        end else begin
            if (m_pv0) m_rd0 <= m_pd0;
            if (m_pv1) m_rd1 <= m_pd1;
            m_pv0 <= (exp_winner() == 0) && !m0_we;
            m_pv1 <= (exp_winner() == 1) && !m1_we;
            m_pd0 <= shadow[m0_addr[7:0]];
            m_pd1 <= shadow[m1_addr[7:0]];
            if (exp_winner() == 0 && m0_we) shadow[m0_addr[7:0]] <= m0_wdata;
            if (exp_winner() == 1 && m1_we) shadow[m1_addr[7:0]] <= m1_wdata;
            if (exp_winner() < 0) m_run <= 0;
            else begin
                m_run  <= (exp_winner() == m_last && m_run > 0) ? m_run + 1 : 1;
                m_last <= exp_winner();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int w;
        w = exp_winner();
        chk("m0_gnt", 64'(m0_gnt), 64'(w == 0));
        chk("m1_gnt", 64'(m1_gnt), 64'(w == 1));
        chk("mem_re", 64'(mem_re), 64'((w == 0 && !m0_we) || (w == 1 && !m1_we)));
        chk("mem_we", 64'(mem_we), 64'((w == 0 && m0_we) || (w == 1 && m1_we)));
        chk("mem_addr", 64'(mem_addr), (w == 0) ? 64'(m0_addr) : (w == 1) ? 64'(m1_addr) : 64'd0);
        chk("mem_wdata", 64'(mem_wdata), (w == 0) ? 64'(m0_wdata) : (w == 1) ? 64'(m1_wdata) : 64'd0);
        chk("m0_rvalid", 64'(m0_rvalid), 64'(m_pv0));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(m_pv1));
        chk("m0_rdata", 64'(m0_rdata), 64'(m_pv0 ? m_pd0 : m_rd0));
        chk("m1_rdata", 64'(m1_rdata), 64'(m_pv1 ? m_pd1 : m_rd1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
        logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
    } vec_t;

    vec_t tbl [8];
    int   seq [9];
    int   exp_seq [9];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
        end
        mem[8'h10]    = 32'hDEADBEEF;
        shadow[8'h10] = 32'hDEADBEEF;

        // Reset held while m0 requests: nothing may be granted
        #1 rst_n = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        repeat (2) begin
            @(negedge clk);
            chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
            chk("rst_mem_re", 64'(mem_re), 64'd0);
            chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        end
        step();
        rst_n = 1'b1;

        // First cycle after release: single read of 0x10
        @(negedge clk);
        chk("lit_first_gnt", 64'(m0_gnt), 64'd1);
        chk("lit_rd_mem_re", 64'(mem_re), 64'd1);
        chk("lit_rd_addr", 64'(mem_addr), 64'h10);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("lit_rd_rvalid", 64'(m0_rvalid), 64'd1);
        chk("lit_rd_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        chk("lit_rd_m1_rvalid", 64'(m1_rvalid), 64'd0);

        // m1 writes 0x1234 to 0x20
        step();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234;
        @(negedge clk);
        chk("lit_wr_we", 64'(mem_we), 64'd1);
        chk("lit_wr_addr", 64'(mem_addr), 64'h20);
        chk("lit_wr_wdata", 64'(mem_wdata), 64'h1234);
        step();
        // m1 reads it back; the write leaves no rvalid behind
        m1_we = 0;
        @(negedge clk);
        chk("lit_wr_no_rvalid", 64'(m1_rvalid), 64'd0);
        step();
        m1_req = 0;
        @(negedge clk);
        chk("lit_rb_rdata", 64'(m1_rdata), 64'h1234);
        step();   // idle cycle, last winner is m1

        // Contention: both read continuously
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h80;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            seq[i] = m1_gnt ? 1 : (m0_gnt ? 0 : 2);
        end
`ifdef MEM_ARB_FAIR_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 9; i++) chk($sformatf("lit_seq%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
        step();
        m0_req = 0;
        @(negedge clk);
        chk("lit_m1_after_drop", 64'(m1_gnt), 64'd1);
        step();
        m1_req = 0;
        step();

        // Mixed traffic, checked by the model
        tbl[0] = '{1'b1, 1'b1, 32'h30, 32'hAAAA0001, 1'b1, 1'b0, 32'h30, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h30, 32'h0,        1'b1, 1'b0, 32'h31, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h31, 32'hBBBB0002};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h31, 32'h0,        1'b1, 1'b0, 32'h30, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h32, 32'hCCCC0003, 1'b1, 1'b0, 32'h31, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h32, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h32, 32'h0};
        for (int i = 0; i < 8; i++) begin
            {m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata} = tbl[i];
            step();
        end
        m0_req = 0; m1_req = 0;
        step();

        // Reset in the cycle after an m1 read grant drops the response
        m1_req = 1; m1_we = 0; m1_addr = 32'h11;
        @(negedge clk);
        chk("lit_mid_gnt", 64'(m1_gnt), 64'd1);
        step();
        rst_n = 1'b0;
        m1_req = 0;
        @(negedge clk);
        chk("lit_mid_rvalid", 64'(m1_rvalid), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_post_rvalid", 64'(m1_rvalid), 64'd0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port of `mem_ctrl` between two masters.
  - m0: the CPU core.
  - m1: a secondary master, e.g. a loader or debug port.
- Arbitrates single-beat reads and writes on a req/gnt handshake.
- Forwards the winning command to the memory in the grant cycle.
- Returns read data to the correct master one cycle later.
- Placement: `cpu_top`, between `core` and `mem_ctrl`.

Parameters:
- ADDR_WIDTH, 32, width of master and memory address buses.
- DATA_WIDTH, 32, width of write/read data buses.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_gnt  out  1  master 0 command accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_WIDTH  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_re.

Behaviour:
- Reset (async on rst_n low, released synchronously by design convention):
  - rvalid/owner pipeline, last-winner pointer (points to m1, so m0 wins first tie) and burst counter are cleared.
  - m0_gnt, m1_gnt, mem_we, mem_re = 0 immediately; m0_rdata, m1_rdata = 0.
- Grant is combinational from mX_req and registered state. At most one gnt per cycle, never both.
- Handshake:
  - Master holds req, we, addr and wdata stable until it sees gnt.
  - A transfer completes on the clock edge where req & gnt = 1.
  - Req held high after gnt is a new request.
- Command path:
  - In the grant cycle, mem_addr and mem_wdata take the winner's addr and wdata.
  - mem_we = winner_we; mem_re = ~winner_we.
  - With no grant: mem_we = mem_re = 0 and mem_addr/mem_wdata = 0.
- Read latency: 1 cycle.
  - The cycle after a read grant to mX, mX_rvalid = 1 for exactly one cycle and mX_rdata = mem_rdata.
  - mX_rdata holds its last value otherwise.
  - Write grants produce no rvalid.
- Arbitration (round-robin + burst limit):
  - Only one master requesting: it wins.
  - Both requesting: the master that did not win most recently wins, unless the current owner has won fewer than MAX_BURST consecutive grants. In that case the owner keeps the port.
  - Burst counter: increments on each grant to the same master, resets to 1 on a change of winner, resets to 0 on an idle cycle.
  - After MAX_BURST consecutive grants with the other master requesting, the other master wins next. Bound on starvation: MAX_BURST cycles.
- Back-to-back: a read may be granted every cycle. Responses pipeline, with rvalid in consecutive cycles, possibly alternating masters.
- Simultaneous read response to mX and new grant to mY in the same cycle: allowed, independent.
- Reset mid-operation: a pending rvalid is dropped and not re-issued. The master must re-request after reset.

Optional Feature:
- Macro MEM_ARB_FAIR_EN.
- Defined: round-robin with MAX_BURST limit, as above.
- Undefined: fixed priority; m0 always wins when requesting. The burst counter and pointer are not built, and MAX_BURST is ignored.

Test Plan:
- Reset: rst_n=0 while m0_req=1 -> all gnt/rvalid/mem_we/mem_re = 0. Release -> m0_gnt=1 in the first cycle.
- Single read: m0 reads addr 0x10, memory returns 0xDEADBEEF -> m0_gnt=1 cycle N, mem_re=1 with mem_addr=0x10 at N, m0_rvalid=1 and m0_rdata=0xDEADBEEF at N+1, m1_rvalid stays 0.
- Write forwarding: m1 writes 0x1234 to 0x20 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 in the grant cycle. No rvalid follows.
- Contention (FAIR_EN, MAX_BURST=4): m0 and m1 request reads continuously -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0.... Each rvalid goes to the matching master, one cycle after its grant.
- Fixed priority (no FAIR_EN): same stimulus -> m0_gnt=1 every cycle and m1_gnt=0 until m0_req drops, then m1 granted the same cycle.
- Reset mid-read: assert rst_n=0 in the cycle after an m1 read grant -> m1_rvalid forced 0 and never asserted for that read.
